// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-file transfer controller: opcodes,
// controller states and the register address width.
package reg_xfer_pkg;

  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOVE = 2'b01,
    OP_SWAP = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B,
    ST_RESP
  } state_e;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Command-driven initiator for the 8-entry register file: LOAD, MOVE, SWAP
// and READ, with read-out data returned on a valid/ready response channel.
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_src,
  input  logic [REG_ADDR_W-1:0] cmd_dst,
  input  logic [WIDTH-1:0]      cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  done,
  output logic                  busy,
  output logic                  rf_read_enable,
  output logic [REG_ADDR_W-1:0] rf_read_addr,
  input  logic [WIDTH-1:0]      rf_read_data,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [WIDTH-1:0]      rf_write_data
);

  state_e                state, state_nxt;
  op_e                   op_q;
  logic [REG_ADDR_W-1:0] src_q, dst_q;
  logic [WIDTH-1:0]      imm_q, tmp_a, tmp_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The read port is only driven in read states, so captures are gated by state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_LOAD;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      tmp_a <= '0;
      tmp_b <= '0;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        op_q  <= op_e'(cmd_op);
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
      if (state == ST_RD_A) tmp_a <= rf_read_data;
      if (state == ST_RD_B) tmp_b <= rf_read_data;
    end
  end

  always_comb begin
    state_nxt       = state;
    cmd_ready       = 1'b0;
    busy            = 1'b1;
    rsp_valid       = 1'b0;
    done            = 1'b0;
    rf_read_enable  = 1'b0;
    rf_write_enable = 1'b0;
    rf_read_addr    = src_q;
    rf_write_addr   = dst_q;
    rf_write_data   = (op_q == OP_LOAD) ? imm_q : tmp_a;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = (op_e'(cmd_op) == OP_LOAD) ? ST_WR_A : ST_RD_A;
        end
      end
      ST_RD_A: begin
        rf_read_enable = 1'b1;
        case (op_q)
          OP_MOVE: state_nxt = ST_WR_A;
          OP_SWAP: state_nxt = ST_RD_B;
          default: state_nxt = ST_RESP;
        endcase
      end
      ST_RD_B: begin
        rf_read_enable = 1'b1;
        rf_read_addr   = dst_q;
        state_nxt      = ST_WR_A;
      end
      ST_WR_A: begin
        rf_write_enable = 1'b1;
        if (op_q == OP_SWAP) begin
          state_nxt = ST_WR_B;
        end else begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_B: begin
        rf_write_enable = 1'b1;
        rf_write_addr   = src_q;
        rf_write_data   = tmp_b;
        done            = 1'b1;
        state_nxt       = ST_IDLE;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_data = tmp_a;

endmodule
